alu_rr_arbiter: RTL and testbench
=================================

# alu_rr_arbiter

Round-robin arbiter that shares one 32-bit, 8-operation ALU between up to eight requesters. Each requester presents an op code and two operands under a valid/ready handshake. The arbiter grants one requester per cycle, drives the ALU, and registers the result into a single-entry output slot tagged with the requester index. It sits between the datapath issue logic and the shared ALU, so the ALU itself stays purely combinational.

## Interface
- N_REQ, default 4: number of requesters, legal range 2..8.
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- req_valid  input  N_REQ  requester i has an operation pending.
- req_op  input  3*N_REQ  op code of requester i, in bits [3i+2:3i].
- req_a  input  32*N_REQ  operand A of requester i, in bits [32i+31:32i].
- req_b  input  32*N_REQ  operand B of requester i, in bits [32i+31:32i].
- req_ready  output  N_REQ  one-hot grant; requester i's operation is accepted in any cycle where req_valid[i] and req_ready[i] are both high.
- rsp_valid  output  1  output slot holds a result.
- rsp_id  output  3  index of the requester that owns the result.
- rsp_y  output  32  ALU result.
- rsp_ready  input  1  consumer accepts the result when rsp_valid and rsp_ready are both high.

## Operation
- ALU op codes:
  - 000: Y=A
  - 001: A+B
  - 010: A-B
  - 011: A&B
  - 100: A|B
  - 101: A+1
  - 110: A-1
  - 111: Y=B
- All arithmetic is modulo 2^32; no carry or overflow output.
- Slot state machine:
  - EMPTY: rsp_valid=0.
  - FULL: rsp_valid=1.
- The slot can accept an operation when it is EMPTY, or when it is FULL with rsp_ready=1 (pass-through: pop and push in the same cycle).
- Grant rule, evaluated combinationally each cycle:
  - If the slot can accept and at least one req_valid bit is set, pick the first set bit searching ptr, ptr+1, …, N_REQ-1, 0, …, ptr-1.
  - Assert req_ready for that bit only; all other req_ready bits are 0.
  - If the slot cannot accept, all req_ready bits are 0.
- On a grant to requester g:
  - The ALU computes on req_op/req_a/req_b of g.
  - At the next edge: rsp_y ← ALU result, rsp_id ← g, rsp_valid ← 1, ptr ← (g+1) mod N_REQ.
- Pop without a grant: rsp_valid ← 0; rsp_y and rsp_id hold their last values.
- No grant and no pop: all state holds.
- ptr changes only on a grant, so an idle cycle does not reset fairness.
- Output stability: while rsp_valid=1 and rsp_ready=0, rsp_y and rsp_id must not change. Requesters keep waiting (req_ready=0).
- req_ready never depends on rsp_y. It may depend on rsp_ready (the pass-through path).
- Requester bits at or above N_REQ do not exist. rsp_id upper bits are 0 whenever N_REQ ≤ 4.

## Timing
- Reset:
  - While reset is high at an edge: rsp_valid←0, rsp_id←0, rsp_y←0, ptr←0.
  - req_ready is forced to 0 combinationally for the whole cycle in which reset is high.
- Latency: the result is visible (rsp_valid=1) in the cycle after the grant cycle.
- Throughput: 1 operation per cycle while rsp_ready is held high.
- Fairness: with all requesters valid continuously and rsp_ready=1, grants rotate 0,1,…,N_REQ-1,0,…. A continuously requesting requester waits at most N_REQ-1 grants.
- Simultaneous pop and grant: the new result replaces the old one at the edge and rsp_valid stays 1 with no bubble.
- Reset mid-operation:
  - A pending result is discarded and never presented.
  - A grant in the reset cycle is suppressed, so no operation is consumed.
- A requester may drop req_valid without being granted. No state is kept for ungranted requests.

## Test plan
- Reset with all 4 requesters valid → req_ready=0000 during reset. In the first cycle after reset, req_ready=0001, rsp_valid=0. One cycle later, rsp_valid=1, rsp_id=0.
- Single requester 2, op 001, A=0xFFFFFFFF, B=2, rsp_ready=1 → grant in cycle t. rsp_y=0x00000001, rsp_id=2 in cycle t+1. ptr=3 afterward.
- All 4 valid, rsp_ready=1 for 8 cycles → grant order 0,1,2,3,0,1,2,3. rsp_valid stays 1 continuously from the second cycle.
- Slot FULL holding result of op 010 (A=5, B=7 → 0xFFFFFFFE), rsp_ready=0 for 3 cycles with requesters 1 and 3 valid → req_ready=0000 and rsp_y/rsp_id unchanged. When rsp_ready rises, requester 1 is granted in that same cycle.
- All 8 op codes from requester 0 with A=0x10, B=0x3 → results 0x10, 0x13, 0x0D, 0x0, 0x13, 0x11, 0x0F, 0x3, in order, each tagged rsp_id=0.
- Reset asserted in the cycle after a grant while rsp_ready=0 → rsp_valid=0 and ptr=0 after reset. No stale result appears, and the next grant goes to the lowest valid index.

Source files
------------

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one combinational 32-bit, 8-op ALU between N_REQ requesters.
// A single registered output slot holds the latest result, tagged with the owner's index.
// N_REQ is legal in the range 2..8; rsp_id is always 3 bits wide.
module alu_rr_arbiter #(
   parameter int unsigned N_REQ = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [N_REQ-1:0]    req_valid,
   input  logic [3*N_REQ-1:0]  req_op,
   input  logic [32*N_REQ-1:0] req_a,
   input  logic [32*N_REQ-1:0] req_b,
   output logic [N_REQ-1:0]    req_ready,
   output logic                rsp_valid,
   output logic [2:0]          rsp_id,
   output logic [31:0]         rsp_y,
   input  logic                rsp_ready
);

   typedef enum logic {SlotEmpty, SlotFull} slot_state_e;

   slot_state_e      state_q;
   logic [2:0]       ptr_q;

   logic [N_REQ-1:0] hi_mask;
   logic [N_REQ-1:0] cand;
   logic             grant_found;
   logic [2:0]       grant_idx;
   logic [2:0]       grant_op;
   logic [31:0]      grant_a;
   logic [31:0]      grant_b;
   logic             can_accept;
   logic             do_grant;
   logic [2:0]       ptr_next;
   logic [31:0]      alu_y;

   // Rotating priority: requesters at or above ptr win first, then wrap to the low indices.
   always_comb begin
      hi_mask = '0;
      for (int i = 0; i < int'(N_REQ); i++) begin
         hi_mask[i] = (3'(i) >= ptr_q);
      end
      cand = ((req_valid & hi_mask) != '0) ? (req_valid & hi_mask) : req_valid;
      grant_found = 1'b0;
      grant_idx   = '0;
      grant_op    = '0;
      grant_a     = '0;
      grant_b     = '0;
      for (int i = 0; i < int'(N_REQ); i++) begin
         if (cand[i] && !grant_found) begin
            grant_found = 1'b1;
            grant_idx   = 3'(i);
            grant_op    = req_op[3*i +: 3];
            grant_a     = req_a[32*i +: 32];
            grant_b     = req_b[32*i +: 32];
         end
      end
   end

   // Slot accepts when empty or when the current result pops in the same cycle.
   always_comb begin
      can_accept = (state_q == SlotEmpty) || rsp_ready;
      do_grant   = grant_found && can_accept && !reset;
      req_ready  = do_grant ? (N_REQ'(1) << grant_idx) : '0;
      ptr_next   = (grant_idx == 3'(N_REQ - 1)) ? 3'd0 : grant_idx + 3'd1;
   end

   // Shared ALU; all arithmetic wraps modulo 2^32.
   always_comb begin
      alu_y = '0;
      unique case (grant_op)
         3'b000:  alu_y = grant_a;
         3'b001:  alu_y = grant_a + grant_b;
         3'b010:  alu_y = grant_a - grant_b;
         3'b011:  alu_y = grant_a & grant_b;
         3'b100:  alu_y = grant_a | grant_b;
         3'b101:  alu_y = grant_a + 32'd1;
         3'b110:  alu_y = grant_a - 32'd1;
         3'b111:  alu_y = grant_b;
         default: alu_y = '0;
      endcase
   end

   // Slot FSM: a grant fills (or refills) the slot, a pop without a grant empties it.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= SlotEmpty;
         rsp_id  <= '0;
         rsp_y   <= '0;
         ptr_q   <= '0;
      end else if (do_grant) begin
         state_q <= SlotFull;
         rsp_id  <= grant_idx;
         rsp_y   <= alu_y;
         ptr_q   <= ptr_next;
      end else if (state_q == SlotFull && rsp_ready) begin
         state_q <= SlotEmpty;
      end
   end

   assign rsp_valid = (state_q == SlotFull);

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Bench for alu_rr_arbiter: directed scenarios plus randomized traffic, all checked
// against a transaction-level model of the slot, pointer and ALU.
module tb_alu_rr_arbiter;

   localparam int N = 4;

   logic            clk = 1'b0;
   logic            reset;
   logic [N-1:0]    req_valid;
   logic [3*N-1:0]  req_op;
   logic [32*N-1:0] req_a;
   logic [32*N-1:0] req_b;
   logic [N-1:0]    req_ready;
   logic            rsp_valid;
   logic [2:0]      rsp_id;
   logic [31:0]     rsp_y;
   logic            rsp_ready;

   int n_checks = 0;
   int n_fail   = 0;

   // Model state
   int          m_ptr;
   logic        m_valid;
   logic [2:0]  m_id;
   logic [31:0] m_y;

   // Per-cycle observations and expectations filled in by tick()
   logic [N-1:0] obs_ready, exp_ready;
   logic         obs_valid, exp_valid;
   logic [2:0]   obs_id, exp_id;
   logic [31:0]  obs_y, exp_y;
   int           exp_g;

   alu_rr_arbiter #(.N_REQ(N)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_op    (req_op),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_id    (rsp_id),
      .rsp_y     (rsp_y),
      .rsp_ready (rsp_ready)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      case (op)
         3'd0:    return a;
         3'd1:    return a + b;
         3'd2:    return a - b;
         3'd3:    return a & b;
         3'd4:    return a | b;
         3'd5:    return a + 32'd1;
         3'd6:    return a - 32'd1;
         default: return b;
      endcase
   endfunction

   // Index granted this cycle, or -1.
   function automatic int model_grant();
      if (reset) return -1;
      if (m_valid && !rsp_ready) return -1;
      for (int k = 0; k < N; k++) begin
         int i;
         i = (m_ptr + k) % N;
         if (req_valid[i]) return i;
      end
      return -1;
   endfunction

   task automatic model_clock(input int g);
      if (reset) begin
         m_valid = 1'b0;
         m_id    = '0;
         m_y     = '0;
         m_ptr   = 0;
      end else if (g >= 0) begin
         m_y     = alu_ref(req_op[3*g +: 3], req_a[32*g +: 32], req_b[32*g +: 32]);
         m_id    = 3'(g);
         m_valid = 1'b1;
         m_ptr   = (g + 1) % N;
      end else if (m_valid && rsp_ready) begin
         m_valid = 1'b0;
      end
   endtask

   // Sample DUT on the falling edge, then advance the model across the rising edge.
   task automatic tick();
      @(negedge clk);
      obs_ready = req_ready;
      obs_valid = rsp_valid;
      obs_id    = rsp_id;
      obs_y     = rsp_y;
      exp_valid = m_valid;
      exp_id    = m_id;
      exp_y     = m_y;
      exp_g     = model_grant();
      exp_ready = (exp_g >= 0) ? (N'(1) << exp_g) : '0;
      @(posedge clk);
      model_clock(exp_g);
      #1;
   endtask

   task automatic set_req(input int i, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b);
      req_op[3*i +: 3]  = op;
      req_a[32*i +: 32] = a;
      req_b[32*i +: 32] = b;
   endtask

   task automatic rand_ops();
      for (int i = 0; i < N; i++) begin
         set_req(i, 3'($urandom_range(0, 7)), $urandom, $urandom);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      req_valid = '1;
      rsp_ready = 1'b1;
      rand_ops();
      tick();
      tick();
      n_checks++;
      if (obs_ready !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_ready: got %b expected 0000", obs_ready);
      end
      reset = 1'b0;
      tick();
      n_checks++;
      if (obs_ready !== 4'b0001) begin
         n_fail++;
         $display("FAIL first_grant: got %b expected 0001", obs_ready);
      end
      n_checks++;
      if (obs_valid !== 1'b0 || obs_y !== 32'h0 || obs_id !== 3'd0) begin
         n_fail++;
         $display("FAIL reset_slot: valid %b id %0d y %h expected 0 0 0", obs_valid, obs_id,
                  obs_y);
      end
      tick();
      n_checks++;
      if (obs_valid !== 1'b1 || obs_id !== 3'd0 || obs_y !== exp_y) begin
         n_fail++;
         $display("FAIL first_result: valid %b id %0d y %h expected 1 0 %h", obs_valid,
                  obs_id, obs_y, exp_y);
      end
   endtask

   task automatic test_single();
      req_valid = '0;
      rsp_ready = 1'b1;
      tick();
      set_req(2, 3'b001, 32'hFFFF_FFFF, 32'd2);
      req_valid = 4'b0100;
      tick();
      n_checks++;
      if (obs_ready !== 4'b0100) begin
         n_fail++;
         $display("FAIL single_grant: got %b expected 0100", obs_ready);
      end
      req_valid = '0;
      tick();
      n_checks++;
      if (obs_valid !== 1'b1 || obs_id !== 3'd2 || obs_y !== 32'h0000_0001) begin
         n_fail++;
         $display("FAIL single_result: valid %b id %0d y %h expected 1 2 00000001", obs_valid,
                  obs_id, obs_y);
      end
      req_valid = '1;
      tick();
      n_checks++;
      if (obs_ready !== 4'b1000) begin
         n_fail++;
         $display("FAIL single_ptr: got %b expected 1000", obs_ready);
      end
   endtask

   task automatic test_fairness();
      req_valid = '1;
      rsp_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         rand_ops();
         tick();
         n_checks++;
         if (obs_ready !== (N'(1) << (i % N))) begin
            n_fail++;
            $display("FAIL rotate[%0d]: got %b expected grant %0d", i, obs_ready, i % N);
         end
         if (i >= 1) begin
            n_checks++;
            if (obs_valid !== 1'b1 || obs_id !== 3'((i - 1) % N) || obs_y !== exp_y) begin
               n_fail++;
               $display("FAIL stream[%0d]: valid %b id %0d y %h expected 1 %0d %h", i,
                        obs_valid, obs_id, obs_y, (i - 1) % N, exp_y);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      req_valid = 4'b0001;
      rsp_ready = 1'b1;
      set_req(0, 3'b010, 32'd5, 32'd7);
      tick();
      n_checks++;
      if (obs_ready !== 4'b0001) begin
         n_fail++;
         $display("FAIL bp_fill: got %b expected 0001", obs_ready);
      end
      rsp_ready = 1'b0;
      req_valid = 4'b1010;
      for (int i = 0; i < 3; i++) begin
         rand_ops();
         tick();
         n_checks++;
         if (obs_ready !== 4'b0000 || obs_valid !== 1'b1 || obs_id !== 3'd0 ||
             obs_y !== 32'hFFFF_FFFE) begin
            n_fail++;
            $display("FAIL bp_hold[%0d]: ready %b valid %b id %0d y %h expected 0000 1 0 fffffffe",
                     i, obs_ready, obs_valid, obs_id, obs_y);
         end
      end
      rsp_ready = 1'b1;
      tick();
      n_checks++;
      if (obs_ready !== 4'b0010 || obs_y !== 32'hFFFF_FFFE) begin
         n_fail++;
         $display("FAIL bp_release: ready %b y %h expected 0010 fffffffe", obs_ready, obs_y);
      end
   endtask

   task automatic test_ops();
      logic [31:0] tbl [8];
      tbl = '{32'h10, 32'h13, 32'h0D, 32'h0, 32'h13, 32'h11, 32'h0F, 32'h3};
      rsp_ready = 1'b1;
      req_valid = 4'b0001;
      for (int k = 0; k <= 8; k++) begin
         if (k < 8) set_req(0, 3'(k), 32'h10, 32'h3);
         else req_valid = '0;
         tick();
         if (k >= 1) begin
            n_checks++;
            if (obs_valid !== 1'b1 || obs_id !== 3'd0 || obs_y !== tbl[k-1]) begin
               n_fail++;
               $display("FAIL op%0d: valid %b id %0d y %h expected 1 0 %h", k - 1, obs_valid,
                        obs_id, obs_y, tbl[k-1]);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      rand_ops();
      req_valid = 4'b0100;
      rsp_ready = 1'b1;
      tick();
      n_checks++;
      if (obs_ready !== 4'b0100) begin
         n_fail++;
         $display("FAIL mid_grant: got %b expected 0100", obs_ready);
      end
      reset = 1'b1;
      rsp_ready = 1'b0;
      req_valid = 4'b1111;
      tick();
      n_checks++;
      if (obs_ready !== 4'b0000) begin
         n_fail++;
         $display("FAIL mid_reset_ready: got %b expected 0000", obs_ready);
      end
      reset = 1'b0;
      req_valid = 4'b1110;
      tick();
      n_checks++;
      if (obs_valid !== 1'b0 || obs_y !== 32'h0 || obs_ready !== 4'b0010) begin
         n_fail++;
         $display("FAIL mid_after: valid %b y %h ready %b expected 0 0 0010", obs_valid, obs_y,
                  obs_ready);
      end
      req_valid = '0;
      rsp_ready = 1'b1;
      tick();
      n_checks++;
      if (obs_valid !== 1'b1 || obs_id !== 3'd1 || obs_y !== exp_y) begin
         n_fail++;
         $display("FAIL mid_result: valid %b id %0d y %h expected 1 1 %h", obs_valid, obs_id,
                  obs_y, exp_y);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         reset     = ($urandom_range(0, 39) == 0);
         req_valid = N'($urandom);
         rsp_ready = ($urandom_range(0, 3) != 0);
         rand_ops();
         tick();
         n_checks++;
         if (obs_ready !== exp_ready || obs_valid !== exp_valid || obs_id !== exp_id ||
             obs_y !== exp_y) begin
            n_fail++;
            $display("FAIL random[%0d]: ready %b valid %b id %0d y %h expected %b %b %0d %h",
                     c, obs_ready, obs_valid, obs_id, obs_y, exp_ready, exp_valid, exp_id,
                     exp_y);
         end
      end
      reset = 1'b0;
   endtask

   initial begin
      m_ptr = 0;
      m_valid = 1'b0;
      m_id = '0;
      m_y = '0;
      reset = 1'b1;
      req_valid = '0;
      req_op = '0;
      req_a = '0;
      req_b = '0;
      rsp_ready = 1'b0;
      test_reset();
      test_single();
      test_fairness();
      test_backpressure();
      test_ops();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
